pipe_stage_skid_reg: RTL

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stage_skid_reg.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline definitions: payload layout, width and write-back select encodings.
package pipe_pkg;

   localparam int unsigned MEM_WB_W = 104;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;
   localparam logic [1:0] WB_SEL_IMM = 2'd3;

   typedef struct packed {
      logic        reg_write;
      logic [31:0] pc;
      logic [31:0] mem_data;
      logic [31:0] alu_result;
      logic [4:0]  dest_addr;
      logic [1:0]  wb_sel;
   } mem_wb_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones; cleared only by rst.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry (main + skid) registered pipeline stage with a flop-driven in_ready.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = MEM_WB_W,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_stall_cnt,
   output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

   if (CNT_W == 0) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              accept;
   logic              drain;

   assign accept = in_valid && !skid_valid_q;
   assign drain  = main_valid_q && out_ready;

   // Main refills from skid first so ordering is preserved; new data lands behind it.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_valid_q && !drain) begin
         if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end
      end else if (skid_valid_q) begin
         main_valid_d = 1'b1;
         main_data_d  = skid_data_q;
         skid_valid_d = accept;
         if (accept) begin
            skid_data_d = in_data;
         end
      end else begin
         main_valid_d = accept;
         if (accept) begin
            main_data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
   logic stall_inc;
   logic bubble_inc;

   assign stall_inc  = main_valid_q && !out_ready;
   assign bubble_inc = !main_valid_q && out_ready;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (perf_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (perf_bubble_cnt)
   );
`endif

endmodule
